// File: rtl/tank_pkg.sv
// Shared types for the tank controller: facing direction, fire FSM states,
// default HID keycodes and the screen-clamp helper.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    F_READY = 2'd0,
    F_REQ   = 2'd1,
    F_COOL  = 2'd2
  } fire_state_t;

  localparam logic [7:0] KEY_UP_DEF    = 8'h1a;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'h16;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h04;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h07;
  localparam logic [7:0] KEY_FIRE_DEF  = 8'h2c;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } key_dec_t;

  // Candidate positions are signed 11-bit so a step past zero shows up as negative.
  function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                           input logic signed [10:0] lo,
                                           input logic signed [10:0] hi);
    logic [9:0] r;
    if (v < lo)
      r = lo[9:0];
    else if (v > hi)
      r = hi[9:0];
    else
      r = v[9:0];
    return r;
  endfunction

endpackage

// File: rtl/tank_fire_ctrl.sv
// Fire request handshake with cooldown: READY -> REQ on fire key, REQ -> COOL
// on ack, COOL -> READY once the frame counter runs out.
module tank_fire_ctrl
  import tank_pkg::*;
#(
  parameter int COOLDOWN = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire_key,
  input  logic       fire_ack,
  input  logic [1:0] cur_dir,
  output logic       fire_req,
  output logic [1:0] fire_dir
);

  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN - 1);

  fire_state_t state, state_next;
  logic [7:0]  cnt, cnt_next;
  dir_t        dir_q, dir_next;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= F_READY;
      cnt   <= 8'd0;
      dir_q <= DIR_UP;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      dir_q <= dir_next;
    end
  end

  // The counter reaching 0 and the return to READY share one edge, so a held
  // fire key re-requests exactly COOLDOWN frames after the ack.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dir_next   = dir_q;
    case (state)
      F_READY: begin
        if (fire_key) begin
          state_next = F_REQ;
          dir_next   = dir_t'(cur_dir);
        end
      end
      F_REQ: begin
        if (fire_ack) begin
          state_next = F_COOL;
          cnt_next   = COOL_LOAD;
        end
      end
      F_COOL: begin
        if (cnt <= 8'd1) begin
          state_next = F_READY;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = F_READY;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_comb begin
    fire_req = (state == F_REQ);
    fire_dir = dir_q;
  end

endmodule

// File: rtl/tank_motion_ctrl.sv
// Per-frame tank motion: resolves up to two HID keycodes into one direction,
// moves one axis by STEP with screen clamping, and hands fire keys to tank_fire_ctrl.
module tank_motion_ctrl
  import tank_pkg::*;
#(
  parameter int         X_MIN     = 0,
  parameter int         X_MAX     = 639,
  parameter int         Y_MIN     = 0,
  parameter int         Y_MAX     = 479,
  parameter int         SIZE      = 32,
  parameter int         STEP      = 5,
  parameter int         X_START   = 320,
  parameter int         Y_START   = 240,
  parameter logic [7:0] KEY_UP    = KEY_UP_DEF,
  parameter logic [7:0] KEY_DOWN  = KEY_DOWN_DEF,
  parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF,
  parameter logic [7:0] KEY_FIRE  = KEY_FIRE_DEF,
  parameter int         COOLDOWN  = 30
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic        clear_up,
  input  logic        clear_down,
  input  logic        clear_left,
  input  logic        clear_right,
  input  logic        fire_ack,
  output logic [9:0]  TankX,
  output logic [9:0]  TankY,
  output logic [1:0]  Direction,
  output logic        moving,
  output logic        fire_req,
  output logic [1:0]  fire_dir
);

  localparam logic signed [10:0] X_LO   = 11'(X_MIN);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE + 1);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE + 1);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t d;
    d.hit = 1'b1;
    d.dir = DIR_UP;
    if (code == KEY_UP)
      d.dir = DIR_UP;
    else if (code == KEY_DOWN)
      d.dir = DIR_DOWN;
    else if (code == KEY_LEFT)
      d.dir = DIR_LEFT;
    else if (code == KEY_RIGHT)
      d.dir = DIR_RIGHT;
    else
      d.hit = 1'b0;
    return d;
  endfunction

  key_dec_t          dec_lo, dec_hi, sel;
  dir_t              dir_q, dir_next;
  logic [9:0]        next_x, next_y;
  logic              moving_next;
  logic signed [10:0] pos_x_s, pos_y_s;
  logic              fire_key;

  // Byte [7:0] wins; the blocked-path case still turns the tank in place.
  always_comb begin
    dec_lo   = decode_key(keycode[7:0]);
    dec_hi   = decode_key(keycode[15:8]);
    sel      = dec_lo.hit ? dec_lo : dec_hi;
    pos_x_s  = $signed({1'b0, TankX});
    pos_y_s  = $signed({1'b0, TankY});
    next_x   = TankX;
    next_y   = TankY;
    dir_next = dir_q;
    if (sel.hit) begin
      dir_next = sel.dir;
      case (sel.dir)
        DIR_UP:    if (clear_up)    next_y = clamp_pos(pos_y_s - STEP_S, Y_LO, Y_HI);
        DIR_DOWN:  if (clear_down)  next_y = clamp_pos(pos_y_s + STEP_S, Y_LO, Y_HI);
        DIR_LEFT:  if (clear_left)  next_x = clamp_pos(pos_x_s - STEP_S, X_LO, X_HI);
        DIR_RIGHT: if (clear_right) next_x = clamp_pos(pos_x_s + STEP_S, X_LO, X_HI);
        default: ;
      endcase
    end
    moving_next = (next_x != TankX) || (next_y != TankY);
    fire_key    = (keycode[7:0] == KEY_FIRE) || (keycode[15:8] == KEY_FIRE);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      TankX  <= 10'(X_START);
      TankY  <= 10'(Y_START);
      dir_q  <= DIR_UP;
      moving <= 1'b0;
    end else begin
      TankX  <= next_x;
      TankY  <= next_y;
      dir_q  <= dir_next;
      moving <= moving_next;
    end
  end

  assign Direction = dir_q;

  tank_fire_ctrl #(
    .COOLDOWN(COOLDOWN)
  ) u_fire (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .fire_key (fire_key),
    .fire_ack (fire_ack),
    .cur_dir  (Direction),
    .fire_req (fire_req),
    .fire_dir (fire_dir)
  );

endmodule
